// File: rtl/mci_serdes_pkg.sv
// ----------------------------------------------------------------------------
// mci_serdes_pkg
// Constants and state type for the block <-> word serialiser.
// Values are for the default 32-bit word bus.
// ----------------------------------------------------------------------------
package mci_serdes_pkg;

    import memory_controller_interface::*;

    localparam int MCI_WORD_WIDTH = 32;
    localparam int BLOCK_WORDS    = MCI_DATA_LENGTH / MCI_WORD_WIDTH;
    localparam int WORD_IDX_BITS  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int OFFSET_LSB_BLK = $clog2(MCI_DATA_LENGTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } mci_serdes_state_t;

endpackage

// File: rtl/memory_controller_interface.sv
// ----------------------------------------------------------------------------
// memory_controller_interface
// Shared cache <-> memory-controller transaction types.
//   mci_request_t  : addr, data (one block), rw (1 = write), valid
//   mci_response_t : ready (one-cycle completion pulse), data (read block)
// ----------------------------------------------------------------------------
package memory_controller_interface;

    localparam int MCI_ADDR_LENGTH = 32;
    localparam int MCI_DATA_LENGTH = 128;

    typedef struct packed {
        logic [MCI_ADDR_LENGTH-1:0] addr;
        logic [MCI_DATA_LENGTH-1:0] data;
        logic                       rw;
        logic                       valid;
    } mci_request_t;

    typedef struct packed {
        logic                       ready;
        logic [MCI_DATA_LENGTH-1:0] data;
    } mci_response_t;

endpackage

// File: rtl/mci_block_assembler.sv
// ----------------------------------------------------------------------------
// mci_block_assembler
// Collects returned read words into a block, in arrival order.
//   clk, rst   : clock, synchronous active-low reset
//   clear      : restart at slot 0 with an empty block
//   load       : store rdata into the current slot and advance
//   rdata      : returned word
//   block_nxt  : block including this cycle's word (valid the same cycle)
//   rx_last    : the word being loaded is the final slot
// ----------------------------------------------------------------------------
module mci_block_assembler #(
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_BITS    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              load,
    input  logic [WORD_WIDTH-1:0]             rdata,
    output logic [WORD_WIDTH*BLOCK_WORDS-1:0] block_nxt,
    output logic                              rx_last
);

    localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(BLOCK_WORDS - 1);

    logic [IDX_BITS-1:0]             rcnt;
    logic [WORD_WIDTH*BLOCK_WORDS-1:0] block_q;

    always_comb begin
        block_nxt = block_q;
        if (load) begin
            block_nxt[WORD_WIDTH*rcnt +: WORD_WIDTH] = rdata;
        end
    end

    assign rx_last = load && (rcnt == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt    <= '0;
            block_q <= '0;
        end else if (clear) begin
            rcnt    <= '0;
            block_q <= '0;
        end else if (load) begin
            rcnt    <= rcnt + IDX_ONE;
            block_q <= block_nxt;
        end
    end

endmodule

// File: rtl/mci_block_serdes.sv
// ----------------------------------------------------------------------------
// mci_block_serdes
// Splits a block-wide cache request into word transfers on a valid/ready
// bus and reassembles read words into a block response.
//   clk, rst    : clock, synchronous active-low reset
//   mem_req     : block request from cache (addr, data, rw, valid)
//   mem_res     : ready pulse + read block back to cache
//   bus_valid/bus_ready/bus_we/bus_addr/bus_wdata : registered word request
//   bus_rvalid/bus_rdata : in-order read word return
//   err         : sticky timeout flag
// Optional: define MCI_SERDES_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES cycles without bus progress; otherwise err is tied 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for mem_req.valid
// ST_WRITE | issuing write words, one per accept
// ST_READ  | issuing read words and collecting returns
// ST_RESP  | one-cycle ready pulse; may accept the next request at once
// ----------------------------------------------------------------------------
module mci_block_serdes
    import memory_controller_interface::*;
    import mci_serdes_pkg::*;
#(
    parameter int WORD_WIDTH     = MCI_WORD_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  mci_request_t          mem_req,
    output mci_response_t         mem_res,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_we,
    output logic [31:0]           bus_addr,
    output logic [WORD_WIDTH-1:0] bus_wdata,
    input  logic                  bus_rvalid,
    input  logic [WORD_WIDTH-1:0] bus_rdata,
    output logic                  err
);

    localparam int BW       = MCI_DATA_LENGTH / WORD_WIDTH;
    localparam int IDXB     = (BW > 1) ? $clog2(BW) : 1;
    localparam int BYTE_LSB = $clog2(WORD_WIDTH / 8);
    localparam int OFF      = OFFSET_LSB_BLK;

    localparam logic [IDXB-1:0] IDX_ONE  = IDXB'(1);
    localparam logic [IDXB-1:0] IDX_LAST = IDXB'(BW - 1);

    mci_serdes_state_t state, next_state;

    logic [31:OFF]              blk_addr;
    logic [MCI_DATA_LENGTH-1:0] lreq_data;
    logic [MCI_DATA_LENGTH-1:0] res_data;
    logic [MCI_DATA_LENGTH-1:0] block_nxt;
    logic [IDXB-1:0]            icnt;
    logic [IDXB-1:0]            icnt_nxt;

    logic start;
    logic issue_fire;
    logic rx_load;
    logic rx_last;
    logic timeout;

    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_req.addr[OFF-1:0];

    // Block offset bits are discarded; the word index replaces them.
    function automatic logic [31:0] word_addr(input logic [31:OFF] a,
                                              input logic [IDXB-1:0] i);
        logic [31:0] r;
        r                  = '0;
        r[31:OFF]          = a;
        r[OFF-1:BYTE_LSB]  = i;
        return r;
    endfunction

    assign issue_fire = bus_valid && bus_ready;
    assign rx_load    = bus_rvalid && (state == ST_READ);
    assign icnt_nxt   = icnt + IDX_ONE;

    mci_block_assembler #(
        .WORD_WIDTH  (WORD_WIDTH),
        .BLOCK_WORDS (BW),
        .IDX_BITS    (IDXB)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .load      (rx_load),
        .rdata     (bus_rdata),
        .block_nxt (block_nxt),
        .rx_last   (rx_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        unique case (state)
            ST_IDLE, ST_RESP: begin
                next_state = ST_IDLE;
                if (mem_req.valid) begin
                    start      = 1'b1;
                    next_state = mem_req.rw ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (timeout || (issue_fire && icnt == IDX_LAST)) begin
                    next_state = ST_RESP;
                end
            end
            ST_READ: begin
                if (timeout || rx_last) begin
                    next_state = ST_RESP;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blk_addr  <= '0;
            lreq_data <= '0;
            icnt      <= '0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            res_data  <= '0;
        end else begin
            if (start) begin
                blk_addr  <= mem_req.addr[31:OFF];
                lreq_data <= mem_req.data;
                icnt      <= '0;
                bus_valid <= 1'b1;
                bus_we    <= mem_req.rw;
                bus_addr  <= word_addr(mem_req.addr[31:OFF], '0);
                bus_wdata <= mem_req.data[WORD_WIDTH-1:0];
            end else if (timeout) begin
                bus_valid <= 1'b0;
                res_data  <= '0;
            end else if (issue_fire) begin
                if (icnt == IDX_LAST) begin
                    bus_valid <= 1'b0;
                end else begin
                    icnt      <= icnt_nxt;
                    bus_addr  <= word_addr(blk_addr, icnt_nxt);
                    bus_wdata <= lreq_data[WORD_WIDTH*icnt_nxt +: WORD_WIDTH];
                end
            end
            // Capture includes the final word arriving on this same edge.
            if (rx_last) begin
                res_data <= block_nxt;
            end
        end
    end

    assign mem_res.ready = (state == ST_RESP);
    assign mem_res.data  = res_data;

`ifdef MCI_SERDES_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt;
    logic          busy;
    logic          progress;

    assign busy     = (state == ST_WRITE) || (state == ST_READ);
    assign progress = issue_fire || rx_load;
    // Terminal count reached with no progress in the current cycle.
    assign timeout  = busy && !progress && (tcnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= TLOAD;
            err  <= 1'b0;
        end else begin
            if (start || progress) begin
                tcnt <= TLOAD;
            end else if (busy && tcnt != '0) begin
                tcnt <= tcnt - TW'(1);
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mci_block_serdes.sv
// ----------------------------------------------------------------------------
// tb_mci_block_serdes
// Directed bench for mci_block_serdes with a 3-cycle read-latency memory.
// ----------------------------------------------------------------------------
module tb_mci_block_serdes;

    import memory_controller_interface::*;

    logic          clk = 1'b0;
    logic          rst;
    mci_request_t  mem_req;
    mci_response_t mem_res;
    logic          bus_valid;
    logic          bus_ready;
    logic          bus_we;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;
    logic          err;

    mci_block_serdes #(
        .WORD_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_res    (mem_res),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [31:0] acc_addr [16];
    logic [31:0] acc_data [16];
    logic        acc_we   [16];
    int          acc_cyc  [16];
    int          n_acc    = 0;
    int          rdy_cnt  = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_wdata = '0;

    logic        dv [3];
    logic [31:0] dd [3];
    logic [31:0] rd_base    = 32'h0;
    logic        dflt_ready = 1'b1;
    logic        pat_en     = 1'b0;
    logic [6:0]  pat        = 7'b1101001;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observe the current cycle, advance one clock, drive the next cycle.
    task automatic step();
        logic fire;
        if (bus_valid && bus_ready && n_acc < 16) begin
            acc_addr[n_acc] = bus_addr;
            acc_data[n_acc] = bus_wdata;
            acc_we[n_acc]   = bus_we;
            acc_cyc[n_acc]  = cyc;
            n_acc++;
        end
        if (mem_res.ready) rdy_cnt++;
        if (prev_stall && bus_valid) begin
            check("stall addr", bus_addr, prev_addr);
            check("stall wdata", bus_wdata, prev_wdata);
        end
        prev_stall = bus_valid && !bus_ready;
        prev_addr  = bus_addr;
        prev_wdata = bus_wdata;
        fire = bus_valid && bus_ready && !bus_we;
        dv[2] = dv[1]; dd[2] = dd[1];
        dv[1] = dv[0]; dd[1] = dd[0];
        dv[0] = fire;  dd[0] = rd_base + {30'd0, bus_addr[3:2]};
        @(posedge clk);
        #1;
        cyc++;
        bus_rvalid = dv[2];
        bus_rdata  = dd[2];
        bus_ready  = (pat_en && cyc >= 1 && cyc <= 7) ? pat[cyc-1] : dflt_ready;
    endtask

    task automatic issue(input logic [31:0] a, input logic [127:0] d, input logic rw);
        mem_req.addr  = a;
        mem_req.data  = d;
        mem_req.rw    = rw;
        mem_req.valid = 1'b1;
        cyc = 0;
        step();
        mem_req.valid = 1'b0;
        n_acc   = 0;
        rdy_cnt = 0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (mem_res.ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, mem_res.ready, 1);
    endtask

    task automatic check_words(input string tag, input logic [31:0] base,
                               input logic [127:0] blk, input logic we,
                               input int c0, input int c1, input int c2, input int c3);
        int ec [4];
        ec = '{c0, c1, c2, c3};
        check({tag, " accepts"}, n_acc, 4);
        for (int i = 0; i < 4; i++) begin
            check({tag, " addr"}, acc_addr[i], base + 32'(4 * i));
            check({tag, " we"}, acc_we[i], we);
            check({tag, " cyc"}, acc_cyc[i], ec[i]);
            if (we) check({tag, " wdata"}, acc_data[i], blk[32*i +: 32]);
        end
    endtask

    task automatic settle_single(input string tag);
        repeat (3) step();
        check({tag, " one pulse"}, rdy_cnt, 1);
    endtask

    logic [127:0] blk;

    initial begin
        dv = '{1'b0, 1'b0, 1'b0};
        dd = '{32'h0, 32'h0, 32'h0};
        rst        = 1'b0;
        mem_req    = '0;
        bus_ready  = 1'b1;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst bus_valid", bus_valid, 0);
        check("rst ready", mem_res.ready, 0);
        check("rst data", mem_res.data, 0);
        check("rst err", err, 0);
        rst = 1'b1;
        step();

        // Plain write
        blk = 128'h44444444_33333333_22222222_11111111;
        issue(32'h0000_1234, blk, 1'b1);
        wait_ready("wr ready", 30);
        check("wr ready cyc", cyc, 5);
        settle_single("wr");
        check_words("wr", 32'h1230, blk, 1'b1, 1, 2, 3, 4);

        // Plain read, 3-cycle latency
        rd_base = 32'hA0;
        issue(32'h0000_0040, '0, 1'b0);
        wait_ready("rd ready", 30);
        check("rd ready cyc", cyc, 8);
        check("rd data", mem_res.data, 128'h000000A3_000000A2_000000A1_000000A0);
        settle_single("rd");
        check("rd data held", mem_res.data, 128'h000000A3_000000A2_000000A1_000000A0);
        check_words("rd", 32'h40, '0, 1'b0, 1, 2, 3, 4);

        // Write with bus_ready stalls
        blk = 128'h88888888_77777777_66666666_55555555;
        pat_en = 1'b1;
        issue(32'h0000_0080, blk, 1'b1);
        wait_ready("stall ready", 30);
        check("stall ready cyc", cyc, 8);
        settle_single("stall");
        pat_en = 1'b0;
        check_words("stall", 32'h80, blk, 1'b1, 1, 4, 6, 7);

        // Writeback followed by fill issued in the RESP cycle
        blk = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        issue(32'h0000_0100, blk, 1'b1);
        wait_ready("b2b wr ready", 30);
        check("b2b wr cyc", cyc, 5);
        check_words("b2b wr", 32'h100, blk, 1'b1, 1, 2, 3, 4);
        rd_base = 32'hB0;
        issue(32'h0000_0200, '0, 1'b0);
        wait_ready("b2b rd ready", 30);
        check("b2b rd cyc", cyc, 8);
        check("b2b rd data", mem_res.data, 128'h000000B3_000000B2_000000B1_000000B0);
        settle_single("b2b rd");
        check_words("b2b rd", 32'h200, '0, 1'b0, 1, 2, 3, 4);

        // Reset after two read words returned
        rd_base = 32'hC0;
        issue(32'h0000_0300, '0, 1'b0);
        while (cyc < 6) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid rst bus_valid", bus_valid, 0);
        check("mid rst data", mem_res.data, 0);
        step();
        check("late rvalid ready", mem_res.ready, 0);
        check("late rvalid data", mem_res.data, 0);
        check("late rvalid valid", bus_valid, 0);
        repeat (4) step();
        check("mid rst no pulse", rdy_cnt, 0);
        rd_base = 32'hA0;
        issue(32'h0000_0040, '0, 1'b0);
        wait_ready("post rst ready", 30);
        check("post rst cyc", cyc, 8);
        check("post rst data", mem_res.data, 128'h000000A3_000000A2_000000A1_000000A0);
        settle_single("post rst");

`ifdef MCI_SERDES_TIMEOUT_EN
        dflt_ready = 1'b0;
        issue(32'h0000_0500, 128'h1, 1'b1);
        wait_ready("to ready", 60);
        check("to cyc", cyc, 17);
        check("to data", mem_res.data, 0);
        check("to err", err, 1);
        settle_single("to");
        check("to accepts", n_acc, 0);
        dflt_ready = 1'b1;
        bus_ready  = 1'b1;
        blk = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;
        issue(32'h0000_0600, blk, 1'b1);
        wait_ready("after to ready", 30);
        check("after to cyc", cyc, 5);
        check("err sticky", err, 1);
        settle_single("after to");
        check_words("after to", 32'h600, blk, 1'b1, 1, 2, 3, 4);
`else
        dflt_ready = 1'b0;
        issue(32'h0000_0500, 128'h1, 1'b1);
        repeat (40) step();
        check("no to pulse", rdy_cnt, 0);
        check("no to err", err, 0);
        check("no to valid", bus_valid, 1);
        dflt_ready = 1'b1;
        bus_ready  = 1'b1;
        wait_ready("no to ready", 30);
        check("no to accepts", n_acc, 4);
        check("no to err end", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
